program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 120 ++++++++++++
 tb/tb_program_loader.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Streams a program image into processor memory, releases the processor from reset,
// lets it run for a fixed number of cycles and captures its result byte.
module program_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RUN_CYCLES = 20
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              s_valid_i,
  input  logic [7:0]        s_data_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              cpu_reset_o,
  input  logic [7:0]        cpu_result_i,
  output logic [7:0]        result_o,
  output logic              done_o,
  output logic              overflow_o
);

  localparam int unsigned     CntW    = $clog2(RUN_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(RUN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PtrMax = '1;

  typedef enum logic [1:0] {StLoad, StRelease, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        result_q, result_d;
  logic              overflow_q, overflow_d;

  logic load_active;
  logic accept;
  logic at_max;

  // Reset gates the handshake combinationally so nothing is written while it is held.
  assign load_active = (state_q == StLoad) && rst_ni;
  assign accept      = load_active && s_valid_i;
  assign at_max      = (ptr_q == PtrMax);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StLoad;
      ptr_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    unique case (state_q)
      StLoad: begin
        if (accept) begin
          // Pointer saturates at the top address; a full memory ends the load.
          if (!at_max) begin
            ptr_d = ptr_q + 1'b1;
          end
          if (s_last_i) begin
            state_d = StRelease;
          end else if (at_max) begin
            overflow_d = 1'b1;
            state_d    = StRelease;
          end
        end
      end
      StRelease: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          result_d = cpu_result_i;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  always_comb begin
    s_ready_o   = load_active;
    mem_we_o    = accept;
    mem_addr_o  = ptr_q;
    mem_wdata_o = s_data_i;
    cpu_reset_o = 1'b0;
    done_o      = 1'b0;
    unique case (state_q)
      StLoad:    cpu_reset_o = 1'b1;
      StRelease: cpu_reset_o = 1'b0;
      StRun:     cpu_reset_o = 1'b0;
      StDone:    done_o      = 1'b1;
      default:   cpu_reset_o = 1'b1;
    endcase
  end

  assign result_o   = result_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a wide instance for load/run/reset scenarios
// and a 4-byte instance for the memory-full case.
module tb_program_loader;

  localparam int unsigned RC_A = 20;
  localparam int unsigned RC_B = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_valid, a_last, a_ready, a_we, a_cpu_reset, a_done, a_ovf;
  logic [7:0] a_data, a_addr, a_wdata, a_cpu_result, a_result;

  logic       b_valid, b_last, b_ready, b_we, b_cpu_reset, b_done, b_ovf;
  logic [7:0] b_data, b_wdata, b_cpu_result, b_result;
  logic [1:0] b_addr;

  program_loader #(.ADDR_W(8), .RUN_CYCLES(RC_A)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .s_valid_i(a_valid), .s_data_i(a_data), .s_last_i(a_last),
    .s_ready_o(a_ready), .mem_we_o(a_we), .mem_addr_o(a_addr), .mem_wdata_o(a_wdata),
    .cpu_reset_o(a_cpu_reset), .cpu_result_i(a_cpu_result), .result_o(a_result),
    .done_o(a_done), .overflow_o(a_ovf)
  );

  program_loader #(.ADDR_W(2), .RUN_CYCLES(RC_B)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .s_valid_i(b_valid), .s_data_i(b_data), .s_last_i(b_last),
    .s_ready_o(b_ready), .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_wdata_o(b_wdata),
    .cpu_reset_o(b_cpu_reset), .cpu_result_i(b_cpu_result), .result_o(b_result),
    .done_o(b_done), .overflow_o(b_ovf)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t q_a[$];
  wr_t q_b[$];
  wr_t e_a, e_b;
  int  n_cmp = 0;
  int  n_err = 0;
  int  exp_ptr_a = 0;

  // Scoreboard monitors: every observed write must match the oldest expected one.
  always begin
    @(posedge clk);
    #4;
    if (a_we === 1'b1) begin
      n_cmp++;
      if (q_a.size() == 0) begin
        n_err++;
        $display("FAIL a_write: got write addr=%0h data=%0h, required no write", a_addr, a_wdata);
      end else begin
        e_a = q_a.pop_front();
        if ({a_addr, a_wdata} !== {e_a.addr, e_a.data}) begin
          n_err++;
          $display("FAIL a_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   a_addr, a_wdata, e_a.addr, e_a.data);
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #4;
    if (b_we === 1'b1) begin
      n_cmp++;
      if (q_b.size() == 0) begin
        n_err++;
        $display("FAIL b_write: got write addr=%0h data=%0h, required no write", b_addr, b_wdata);
      end else begin
        e_b = q_b.pop_front();
        if ({6'b0, b_addr, b_wdata} !== {e_b.addr, e_b.data}) begin
          n_err++;
          $display("FAIL b_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   b_addr, b_wdata, e_b.addr, e_b.data);
        end
      end
    end
  end

  // Returns 2 time units after a rising edge, the point where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    a_valid = 1'b0;
    a_last  = 1'b0;
    b_valid = 1'b0;
    b_last  = 1'b0;
    tick();
    rst_n     = 1'b1;
    exp_ptr_a = 0;
    #2;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    tick();
    #2;
    n_cmp++;
    if ({a_ready, a_we, b_ready, b_we} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_hold: got ready/we a=%b%b b=%b%b, required 0000",
               a_ready, a_we, b_ready, b_we);
    end
    tick();
    rst_n   = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    #2;
    n_cmp++;
    if ({a_ready, a_cpu_reset, a_we, a_done, a_ovf} !== 5'b11000) begin
      n_err++;
      $display("FAIL reset_state: got ready,cpu_reset,we,done,ovf=%b%b%b%b%b, required 11000",
               a_ready, a_cpu_reset, a_we, a_done, a_ovf);
    end
    n_cmp++;
    if (a_result !== 8'h00) begin
      n_err++;
      $display("FAIL reset_result: got %0h, required 00", a_result);
    end
    n_cmp++;
    if ({b_ready, b_cpu_reset, b_ovf} !== 3'b110) begin
      n_err++;
      $display("FAIL reset_b: got ready,cpu_reset,ovf=%b%b%b, required 110",
               b_ready, b_cpu_reset, b_ovf);
    end
  endtask

  task automatic load_a(input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        tick();
        a_valid = 1'b0;
        a_data  = 8'hEE;
        #2;
        n_cmp++;
        if (a_we !== 1'b0) begin
          n_err++;
          $display("FAIL gap_idle: got mem_we=%b, required 0", a_we);
        end
      end
      tick();
      a_valid = 1'b1;
      a_data  = 8'(8'h11 * (i + 1));
      a_last  = (i == 3);
      q_a.push_back('{addr: 8'(exp_ptr_a), data: a_data});
      exp_ptr_a++;
      #2;
      n_cmp++;
      if ({a_ready, a_cpu_reset} !== 2'b11) begin
        n_err++;
        $display("FAIL load_state: got ready,cpu_reset=%b%b, required 11", a_ready, a_cpu_reset);
      end
    end
    tick();
    a_valid = 1'b0;
    a_last  = 1'b0;
    #2;
    n_cmp++;
    if ({a_cpu_reset, a_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL release: got cpu_reset,ready=%b%b, required 00", a_cpu_reset, a_ready);
    end
    n_cmp++;
    if (q_a.size() != 0) begin
      n_err++;
      $display("FAIL load_writes: got %0d writes missing, required 0", q_a.size());
    end
  endtask

  // Entered while in the release cycle; input stream held valid to confirm it is ignored.
  task automatic test_run_capture();
    a_cpu_result = 8'h05;
    a_valid      = 1'b1;
    a_data       = 8'h99;
    for (int i = 1; i <= int'(RC_A); i++) begin
      tick();
      #2;
      n_cmp++;
      if ({a_done, a_ready, a_we, a_cpu_reset} !== 4'b0000) begin
        n_err++;
        $display("FAIL run_cycle%0d: got done,ready,we,cpu_reset=%b%b%b%b, required 0000",
                 i, a_done, a_ready, a_we, a_cpu_reset);
      end
    end
    n_cmp++;
    if (a_result !== 8'h00) begin
      n_err++;
      $display("FAIL run_no_early: got result %0h, required 00", a_result);
    end
    tick();
    #2;
    n_cmp++;
    if ({a_done, a_result} !== {1'b1, 8'h05}) begin
      n_err++;
      $display("FAIL capture: got done=%b result=%0h, required done=1 result=05",
               a_done, a_result);
    end
    a_cpu_result = 8'hAA;
    repeat (3) tick();
    #2;
    n_cmp++;
    if ({a_done, a_result, a_ready, a_we} !== {1'b1, 8'h05, 2'b00}) begin
      n_err++;
      $display("FAIL done_hold: got done=%b result=%0h ready=%b we=%b, required 1 05 0 0",
               a_done, a_result, a_ready, a_we);
    end
    a_valid = 1'b0;
  endtask

  // Entered while in the release cycle of a fresh load.
  task automatic test_reset_mid_run();
    a_cpu_result = 8'h5A;
    repeat (11) tick();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({a_done, a_cpu_reset} !== 2'b00) begin
      n_err++;
      $display("FAIL mid_run: got done,cpu_reset=%b%b, required 00", a_done, a_cpu_reset);
    end
    tick();
    rst_n     = 1'b1;
    exp_ptr_a = 0;
    #2;
    n_cmp++;
    if ({a_cpu_reset, a_done, a_ready, a_result} !== {3'b101, 8'h00}) begin
      n_err++;
      $display("FAIL abort: got cpu_reset,done,ready=%b%b%b result=%0h, required 101 00",
               a_cpu_reset, a_done, a_ready, a_result);
    end
    tick();
    a_valid = 1'b1;
    a_data  = 8'h77;
    a_last  = 1'b1;
    q_a.push_back('{addr: 8'h00, data: 8'h77});
    tick();
    a_valid = 1'b0;
    a_last  = 1'b0;
    #2;
    n_cmp++;
    if ({a_cpu_reset, q_a.size() == 0} !== 2'b01) begin
      n_err++;
      $display("FAIL reload: got cpu_reset=%b pending=%0d, required 0 0",
               a_cpu_reset, q_a.size());
    end
  endtask

  task automatic test_overflow();
    bit loading = 1'b1;
    bit ovf     = 1'b0;
    int ptr     = 0;
    b_cpu_result = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      tick();
      b_valid = 1'b1;
      b_last  = 1'b0;
      b_data  = 8'(8'hA0 + i);
      if (loading) q_b.push_back('{addr: 8'(ptr), data: b_data});
      #2;
      n_cmp++;
      if ({b_ready, b_ovf} !== {loading, ovf}) begin
        n_err++;
        $display("FAIL ovf_byte%0d: got ready=%b ovf=%b, required ready=%b ovf=%b",
                 i, b_ready, b_ovf, loading, ovf);
      end
      if (loading) begin
        if (ptr == 3) begin
          loading = 1'b0;
          ovf     = 1'b1;
        end else begin
          ptr++;
        end
      end
    end
    n_cmp++;
    if ({b_cpu_reset, b_we} !== 2'b00) begin
      n_err++;
      $display("FAIL ovf_release: got cpu_reset,we=%b%b, required 00", b_cpu_reset, b_we);
    end
    b_valid = 1'b0;
    repeat (RC_B) tick();
    #2;
    n_cmp++;
    if (b_done !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_run: got done=%b, required 0", b_done);
    end
    tick();
    #2;
    n_cmp++;
    if ({b_done, b_result, b_ovf} !== {1'b1, 8'h3C, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_capture: got done=%b result=%0h ovf=%b, required 1 3c 1",
               b_done, b_result, b_ovf);
    end
    n_cmp++;
    if (q_b.size() != 0) begin
      n_err++;
      $display("FAIL ovf_writes: got %0d writes missing, required 0", q_b.size());
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    a_valid      = 1'b0;
    a_last       = 1'b0;
    a_data       = 8'h00;
    a_cpu_result = 8'h00;
    b_valid      = 1'b0;
    b_last       = 1'b0;
    b_data       = 8'h00;
    b_cpu_result = 8'h00;

    test_reset();
    load_a(1'b0);
    test_run_capture();
    do_reset();
    load_a(1'b1);
    test_reset_mid_run();
    do_reset();
    test_overflow();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
